// File: rtl/aes_ctrl_pkg.sv
// Shared types and widths for the AES core arbiter: FSM state encoding and
// block/key/watchdog widths.
package aes_ctrl_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_KEY_W = 256;
    localparam int WDOG_W    = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        DRAIN,
        RESP
    } arb_state_t;

endpackage

// File: rtl/aes_core_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found by
// searching upward from ptr_i+1 with wrap-around.
module rr_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               gnt_vld_o
);

    always_comb begin
        int              cand;
        logic [ID_W-1:0] idx;
        logic            found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        cand      = 0;
        idx       = '0;
        found     = 1'b0;
        // The last probe (i == NUM_REQ) lands back on ptr_i itself, so the
        // previous winner is only chosen when nobody else is asking.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(ptr_i) + i) % NUM_REQ;
            idx  = ID_W'(cand);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
        gnt_vld_o = found;
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES-256 core among NUM_REQ requesters: round-robin grant, core
// restart pulse, gated run with watchdog, and an id-tagged response.
module aes_core_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                           clk_g,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   req_plaintext_i,
    input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key_i,
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic [ID_W-1:0]                resp_id_o,
    output logic [AES_BLK_W-1:0]           resp_ciphertext_o,
    output logic                           resp_error_o,
    output logic                           core_rst_n_o,
    output logic                           core_en_o,
    output logic [AES_BLK_W-1:0]           core_plaintext_o,
    output logic [AES_KEY_W-1:0]           core_key_o,
    input  logic                           core_done_i,
    input  logic [AES_BLK_W-1:0]           core_ciphertext_i,
    output logic                           busy_o
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    arb_state_t             state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [AES_BLK_W-1:0]   pt_q, pt_d;
    logic [AES_KEY_W-1:0]   key_q, key_d;
    logic [AES_BLK_W-1:0]   ct_q, ct_d;
    logic                   err_q, err_d;
    logic [WDOG_W-1:0]      wdog_q, wdog_d;

    logic [NUM_REQ-1:0]     gnt;
    logic [ID_W-1:0]        gnt_idx;
    logic                   gnt_vld;
    logic [AES_BLK_W-1:0]   sel_pt;
    logic [AES_KEY_W-1:0]   sel_key;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    always_comb begin
        sel_pt  = '0;
        sel_key = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_pt  = req_plaintext_i[i*AES_BLK_W +: AES_BLK_W];
                sel_key = req_key_i[i*AES_KEY_W +: AES_KEY_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        pt_d    = pt_q;
        key_d   = key_q;
        ct_d    = ct_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    ptr_d   = gnt_idx;
                    id_d    = gnt_idx;
                    pt_d    = sel_pt;
                    key_d   = sel_key;
                    state_d = START;
                end
            end
            START: begin
                wdog_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                wdog_d = wdog_q + 1'b1;
                // A done arriving on the watchdog's last cycle still wins.
                if (core_done_i) begin
                    state_d = DRAIN;
                end else if (wdog_q == WDOG_LAST) begin
                    ct_d    = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            DRAIN: begin
                ct_d    = core_ciphertext_i;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            pt_q    <= '0;
            key_q   <= '0;
            ct_q    <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    // Ready is gated by rst_n so nothing is offered while reset is held.
    assign req_ready_o       = {NUM_REQ{rst_n && (state_q == IDLE)}} & gnt;
    assign resp_valid_o      = (state_q == RESP);
    assign resp_id_o         = id_q;
    assign resp_ciphertext_o = ct_q;
    assign resp_error_o      = err_q;
    assign core_rst_n_o      = rst_n && (state_q != START);
    assign core_en_o         = (state_q == RUN) || (state_q == DRAIN);
    assign core_plaintext_o  = pt_q;
    assign core_key_o        = key_q;
    assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed, scoreboarded bench for aes_core_arbiter with a behavioural core
// whose done timing is programmable per job.
module tb_aes_core_arbiter;

    localparam int NR = 4;
    localparam logic [127:0] VEC_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] VEC_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] VEC_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic [1:0]   id;
        logic [127:0] ct;
        logic         err;
    } exp_t;

    logic              clk_g;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready_o;
    logic [NR*128-1:0] req_plaintext;
    logic [NR*256-1:0] req_key;
    logic              resp_valid_o;
    logic              resp_ready;
    logic [1:0]        resp_id_o;
    logic [127:0]      resp_ciphertext_o;
    logic              resp_error_o;
    logic              core_rst_n_o;
    logic              core_en_o;
    logic [127:0]      core_plaintext_o;
    logic [255:0]      core_key_o;
    logic              core_done_i;
    logic [127:0]      core_ct;
    logic              busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = 0;
    int en_cycles = 0;
    int rst_pulses = 0;
    bit keep_valid = 1'b0;
    exp_t sb_q[$];
    int   grant_q[$];

    logic [31:0] run_cnt;
    logic [31:0] done_at;

    aes_core_arbiter #(
        .NUM_REQ        (NR),
        .ID_W           (2),
        .TIMEOUT_CYCLES (1023)
    ) dut (
        .clk_g             (clk_g),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready_o),
        .req_plaintext_i   (req_plaintext),
        .req_key_i         (req_key),
        .resp_valid_o      (resp_valid_o),
        .resp_ready_i      (resp_ready),
        .resp_id_o         (resp_id_o),
        .resp_ciphertext_o (resp_ciphertext_o),
        .resp_error_o      (resp_error_o),
        .core_rst_n_o      (core_rst_n_o),
        .core_en_o         (core_en_o),
        .core_plaintext_o  (core_plaintext_o),
        .core_key_o        (core_key_o),
        .core_done_i       (core_done_i),
        .core_ciphertext_i (core_ct),
        .busy_o            (busy_o)
    );

    initial clk_g = 1'b0;
    always #5 clk_g = ~clk_g;

    // Stand-in for the AES core: the FIPS-197 vector is reproduced exactly,
    // any other job gets a distinct key/plaintext-dependent value.
    function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [255:0] k);
        if (pt == VEC_PT && k == VEC_KEY) return VEC_CT;
        return pt ^ k[127:0] ^ k[255:128] ^ 128'h5a5a_0000_a5a5_ffff_0f0f_f0f0_3c3c_c3c3;
    endfunction

    always @(posedge clk_g or negedge core_rst_n_o) begin
        if (!core_rst_n_o) begin
            run_cnt <= '0;
            core_ct <= '0;
        end else begin
            if (core_en_o) run_cnt <= run_cnt + 32'd1;
            if (core_done_i) core_ct <= model_ct(core_plaintext_o, core_key_o);
        end
    end
    assign core_done_i = core_en_o && (run_cnt == done_at);

    always @(posedge clk_g) begin
        cyc <= cyc + 1;
        if (core_done_i) done_cyc <= cyc;
        if (core_en_o) en_cycles <= en_cycles + 1;
        if (rst_n && !core_rst_n_o) rst_pulses <= rst_pulses + 1;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample ready just before the edge, retire granted requests
    // after it, and return at the following falling edge.
    task automatic tick();
        logic [NR-1:0] rdy;
        #1;
        rdy = req_ready_o;
        @(posedge clk_g);
        #1;
        if (rdy != '0) begin
            check("ready_onehot", 256'($onehot(rdy)), 256'(1));
            for (int i = 0; i < NR; i++) if (rdy[i]) grant_q.push_back(i);
            if (!keep_valid) req_valid = req_valid & ~rdy;
        end
        @(negedge clk_g);
    endtask

    task automatic set_req(input int ch, input logic [127:0] pt, input logic [255:0] key, input bit push);
        exp_t e;
        req_plaintext[128*ch +: 128] = pt;
        req_key[256*ch +: 256]       = key;
        req_valid[ch]                = 1'b1;
        if (push) begin
            e.id  = 2'(ch);
            e.ct  = model_ct(pt, key);
            e.err = 1'b0;
            sb_q.push_back(e);
        end
    endtask

    task automatic push_err(input int ch);
        exp_t e;
        e.id  = 2'(ch);
        e.ct  = '0;
        e.err = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic wait_resp(input string tag, input int max_cyc, input bit chk_lat);
        int   n;
        exp_t e;
        n = 0;
        while (!resp_valid_o && n < max_cyc) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 256'(resp_valid_o), 256'(1));
        if (resp_valid_o) begin
            if (chk_lat) check({tag, "_latency"}, 256'(cyc - done_cyc), 256'(2));
            check({tag, "_sb_nonempty"}, 256'(sb_q.size() != 0), 256'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({tag, "_id"}, 256'(resp_id_o), 256'(e.id));
                check({tag, "_ct"}, 256'(resp_ciphertext_o), 256'(e.ct));
                check({tag, "_err"}, 256'(resp_error_o), 256'(e.err));
            end
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            check({tag, "_valid_drop"}, 256'(resp_valid_o), 256'(0));
        end
    endtask

    logic [127:0] mpt [NR];
    logic [255:0] mkey[NR];

    initial begin
        int           rp0;
        int           en0;
        int           n;
        exp_t         e;
        logic [127:0] hold_ct;

        rst_n         = 1'b0;
        req_valid     = 4'b0001;
        req_plaintext = '0;
        req_key       = '0;
        resp_ready    = 1'b0;
        done_at       = 32'd3;

        // Reset state, with a request already present.
        @(negedge clk_g);
        @(negedge clk_g);
        #1;
        check("rst_ready", 256'(req_ready_o), 256'(0));
        check("rst_resp_valid", 256'(resp_valid_o), 256'(0));
        check("rst_resp_id", 256'(resp_id_o), 256'(0));
        check("rst_resp_ct", 256'(resp_ciphertext_o), 256'(0));
        check("rst_resp_err", 256'(resp_error_o), 256'(0));
        check("rst_core_rst_n", 256'(core_rst_n_o), 256'(0));
        check("rst_core_en", 256'(core_en_o), 256'(0));
        check("rst_core_pt", 256'(core_plaintext_o), 256'(0));
        check("rst_core_key", 256'(core_key_o), 256'(0));
        check("rst_busy", 256'(busy_o), 256'(0));
        req_valid = '0;
        @(negedge clk_g);
        rst_n = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 3; i++) tick();
        check("idle_busy", 256'(busy_o), 256'(0));
        check("idle_ready", 256'(req_ready_o), 256'(0));

        // All channels valid continuously: fairness after reset.
        for (int c = 0; c < NR; c++) begin
            mpt[c]  = {4{32'h1000_0000 + 32'(c)}};
            mkey[c] = {8{32'hc0de_0000 + 32'(c * 17)}};
            set_req(c, mpt[c], mkey[c], 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            e.id  = 2'(k % NR);
            e.ct  = model_ct(mpt[k % NR], mkey[k % NR]);
            e.err = 1'b0;
            sb_q.push_back(e);
        end
        grant_q.delete();
        keep_valid = 1'b1;
        for (int k = 0; k < 8; k++) wait_resp("rr", 100, 1'b0);
        keep_valid = 1'b0;
        req_valid  = '0;
        check("rr_grant_count", 256'(grant_q.size()), 256'(8));
        for (int k = 0; k < 8 && k < grant_q.size(); k++)
            check("rr_grant_order", 256'(grant_q[k]), 256'(k % NR));

        // Single request on ch2 with the reference vector.
        done_at = 32'd59;
        rp0 = rst_pulses;
        set_req(2, VEC_PT, VEC_KEY, 1'b1);
        #1;
        check("single_ready", 256'(req_ready_o), 256'(4'b0100));
        tick();
        check("single_ready_pulse", 256'(req_ready_o), 256'(0));
        check("start_core_rst", 256'(core_rst_n_o), 256'(0));
        check("start_core_pt", 256'(core_plaintext_o), 256'(VEC_PT));
        check("start_core_key", 256'(core_key_o), 256'(VEC_KEY));
        check("start_busy", 256'(busy_o), 256'(1));
        tick();
        check("run_core_en", 256'(core_en_o), 256'(1));
        check("run_core_rst", 256'(core_rst_n_o), 256'(1));
        wait_resp("single", 200, 1'b1);
        check("single_rst_pulses", 256'(rst_pulses - rp0), 256'(1));

        // Response held off for 20 cycles while other channels request.
        done_at = 32'd10;
        set_req(3, 128'hfeed_beef_0000_1111_2222_3333_4444_5555, {8{32'h0bad_cafe}}, 1'b1);
        hold_ct = model_ct(128'hfeed_beef_0000_1111_2222_3333_4444_5555, {8{32'h0bad_cafe}});
        n = 0;
        while (!resp_valid_o && n < 100) begin
            tick();
            n++;
        end
        check("hold_reach_resp", 256'(resp_valid_o), 256'(1));
        set_req(1, 128'h0101_0202_0303_0404_0505_0606_0707_0808, {4{64'h1357_9bdf_2468_ace0}}, 1'b1);
        set_req(0, 128'h9999_0000_9999_0000_9999_0000_9999_0000, {4{64'h1}}, 1'b0);
        rp0 = rst_pulses;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_valid", 256'(resp_valid_o), 256'(1));
            check("hold_id", 256'(resp_id_o), 256'(3));
            check("hold_ct", 256'(resp_ciphertext_o), 256'(hold_ct));
            check("hold_ready", 256'(req_ready_o), 256'(0));
        end
        req_valid[0] = 1'b0;
        check("hold_no_core_rst", 256'(rst_pulses - rp0), 256'(0));
        wait_resp("hold", 5, 1'b0);
        #1;
        check("b2b_ready", 256'(req_ready_o), 256'(4'b0010));
        wait_resp("b2b", 100, 1'b0);

        // Core never finishes: watchdog abort, then a normal job.
        done_at = 32'hffff_ffff;
        set_req(0, 128'h7777_6666_5555_4444_3333_2222_1111_0000, {8{32'h2222_3333}}, 1'b0);
        push_err(0);
        en0 = en_cycles;
        wait_resp("timeout", 1100, 1'b0);
        check("timeout_run_cycles", 256'(en_cycles - en0), 256'(1023));
        done_at = 32'd5;
        set_req(2, 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100, {8{32'h4444_5555}}, 1'b1);
        wait_resp("after_timeout", 100, 1'b0);

        // Done on the watchdog's terminal cycle.
        done_at = 32'd1022;
        set_req(3, 128'habcd_ef01_2345_6789_abcd_ef01_2345_6789, {8{32'h6666_7777}}, 1'b1);
        en0 = en_cycles;
        wait_resp("terminal", 1100, 1'b0);
        check("terminal_en_cycles", 256'(en_cycles - en0), 256'(1024));

        // Reset in cycle 30 of RUN.
        done_at = 32'd200;
        set_req(3, 128'h1111_2222_3333_4444_5555_6666_7777_8888, {8{32'h8888_9999}}, 1'b0);
        n = 0;
        while (!core_en_o && n < 10) begin
            tick();
            n++;
        end
        check("midrst_reach_run", 256'(core_en_o), 256'(1));
        for (int i = 0; i < 29; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 256'(busy_o), 256'(0));
        check("midrst_core_rst", 256'(core_rst_n_o), 256'(0));
        check("midrst_core_en", 256'(core_en_o), 256'(0));
        check("midrst_resp_valid", 256'(resp_valid_o), 256'(0));
        check("midrst_core_pt", 256'(core_plaintext_o), 256'(0));
        check("midrst_core_key", 256'(core_key_o), 256'(0));
        check("midrst_resp_id", 256'(resp_id_o), 256'(0));
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("midrst_no_resp", 256'(resp_valid_o), 256'(0));
        done_at = 32'd20;
        set_req(1, 128'hcafe_f00d_cafe_f00d_cafe_f00d_cafe_f00d, {8{32'hdead_0001}}, 1'b1);
        wait_resp("after_midrst", 100, 1'b0);

        check("sb_drained", 256'(sb_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
